keypad_scan_ctrl: RTL and testbench



---
 rtl/keypad_scan_if.sv | 22 ++
 rtl/keypad_scan_ctrl.sv | 182 ++++++++++++++++++
 tb/tb_keypad_scan_ctrl.sv | 277 +++++++++++++++++++++++++++
 3 files changed

// File: rtl/keypad_scan_if.sv
// Keypad pin and key-consumer handshake bundle for keypad_scan_ctrl.
// master is the controller side, slave is the keypad/consumer side.
interface keypad_scan_if;
  logic [3:0] kpr;
  logic [3:0] kpc;
  logic [3:0] key_code;
  logic       key_valid;
  logic       key_ready;
  logic       key_held;
  logic       overrun;
  logic       clr_overrun;

  modport master (
    input  kpr, key_ready, clr_overrun,
    output kpc, key_code, key_valid, key_held, overrun
  );

  modport slave (
    output kpr, key_ready, clr_overrun,
    input  kpc, key_code, key_valid, key_held, overrun
  );
endinterface

// File: rtl/keypad_scan_ctrl.sv
// 4x4 matrix keypad scanner: column strobing, press/release debounce,
// key encoding and valid/ready delivery with sticky overrun.
//
// state    | meaning
// SCAN     | no key seen, rotating the column strobe every SCAN_DIV cycles
// PRESS_DB | column frozen, counting stable cycles of the candidate row
// ACCEPT   | one cycle: publish key_code/key_valid or flag overrun
// HELD     | key reported, waiting for all rows to go idle
// REL_DB   | counting stable idle cycles before resuming the scan
module keypad_scan_ctrl #(
  parameter int unsigned SCAN_DIV = 1000,
  parameter int unsigned DEBOUNCE = 20000
) (
  input  logic          clk,
  input  logic          reset_n,
  keypad_scan_if.master kp
);

  typedef enum logic [2:0] {
    S_SCAN,
    S_PRESS_DB,
    S_ACCEPT,
    S_HELD,
    S_REL_DB
  } state_t;

  localparam int DIV_W = $clog2(SCAN_DIV);
  localparam int DB_W  = $clog2(DEBOUNCE);
  localparam logic [DIV_W-1:0] DIV_LAST = DIV_W'(SCAN_DIV - 1);
  // Exit compare is one below the terminal value so the counter lands on DEBOUNCE-1 as the state changes.
  localparam logic [DB_W-1:0]  DB_EXIT  = DB_W'(DEBOUNCE - 2);

  state_t            state_q, state_d;
  logic [3:0]        kpr_s1, kprs;
  logic [1:0]        col_q, col_d;
  logic [DIV_W-1:0]  div_q, div_d;
  logic [DB_W-1:0]   cnt_q, cnt_d;
  logic [3:0]        cand_q, cand_d;
  logic [3:0]        code_q, code_d;
  logic              valid_q, valid_d;
  logic              held_q, held_d;
  logic              ovr_q, ovr_d;
  logic              idle;
  logic              stable;

  function automatic logic row_single(input logic [3:0] r);
    return (r == 4'b0111) || (r == 4'b1011) || (r == 4'b1101) || (r == 4'b1110);
  endfunction

  function automatic logic [1:0] row_index(input logic [3:0] r);
    logic [1:0] idx;
    idx = 2'd0;
    case (r)
      4'b1011: idx = 2'd1;
      4'b1101: idx = 2'd2;
      4'b1110: idx = 2'd3;
      default: idx = 2'd0;
    endcase
    return idx;
  endfunction

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      kpr_s1 <= 4'hF;
      kprs   <= 4'hF;
    end else begin
      kpr_s1 <= kp.kpr;
      kprs   <= kpr_s1;
    end
  end

  assign idle   = (kprs == 4'hF);
  assign stable = (kprs == cand_q) && row_single(kprs);

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) state_q <= S_SCAN;
    else          state_q <= state_d;
  end

  always_comb begin
    state_d = state_q;
    case (state_q)
      S_SCAN:     if (!idle) state_d = S_PRESS_DB;
      S_PRESS_DB: begin
        if (!stable)              state_d = S_SCAN;
        else if (cnt_q == DB_EXIT) state_d = S_ACCEPT;
      end
      S_ACCEPT:   state_d = S_HELD;
      S_HELD:     if (idle) state_d = S_REL_DB;
      S_REL_DB: begin
        if (!idle)                 state_d = S_HELD;
        else if (cnt_q == DB_EXIT) state_d = S_SCAN;
      end
      default:    state_d = S_SCAN;
    endcase
  end

  always_comb begin
    col_d   = col_q;
    div_d   = div_q;
    cnt_d   = cnt_q;
    cand_d  = cand_q;
    code_d  = code_q;
    valid_d = valid_q;
    held_d  = held_q;
    ovr_d   = ovr_q;
    if (valid_q && kp.key_ready) valid_d = 1'b0;
    if (kp.clr_overrun)          ovr_d   = 1'b0;
    case (state_q)
      S_SCAN: begin
        if (idle) begin
          if (div_q == DIV_LAST) begin
            div_d = '0;
            col_d = col_q + 2'd1;
          end else begin
            div_d = div_q + 1'b1;
          end
        end else begin
          cnt_d  = '0;
          cand_d = kprs;
        end
      end
      S_PRESS_DB: begin
        if (stable) cnt_d = cnt_q + 1'b1;
        else        div_d = '0;
      end
      S_ACCEPT: begin
        held_d = 1'b1;
        // A transfer on this same edge frees the slot, so only an unconsumed key is an overrun.
        if (valid_q && !kp.key_ready) begin
          ovr_d = 1'b1;
        end else begin
          valid_d = 1'b1;
          code_d  = {row_index(cand_q), col_q};
        end
      end
      S_HELD: begin
        if (idle) cnt_d = '0;
      end
      S_REL_DB: begin
        if (idle) begin
          cnt_d = cnt_q + 1'b1;
          if (cnt_q == DB_EXIT) begin
            held_d = 1'b0;
            col_d  = col_q + 2'd1;
            div_d  = '0;
          end
        end
      end
      default: ;
    endcase
  end

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      col_q   <= 2'd0;
      div_q   <= '0;
      cnt_q   <= '0;
      cand_q  <= 4'hF;
      code_q  <= 4'd0;
      valid_q <= 1'b0;
      held_q  <= 1'b0;
      ovr_q   <= 1'b0;
    end else begin
      col_q   <= col_d;
      div_q   <= div_d;
      cnt_q   <= cnt_d;
      cand_q  <= cand_d;
      code_q  <= code_d;
      valid_q <= valid_d;
      held_q  <= held_d;
      ovr_q   <= ovr_d;
    end
  end

  assign kp.kpc       = ~(4'b1000 >> col_q);
  assign kp.key_code  = code_q;
  assign kp.key_valid = valid_q;
  assign kp.key_held  = held_q;
  assign kp.overrun   = ovr_q;

endmodule

// File: tb/tb_keypad_scan_ctrl.sv
// Directed bench for keypad_scan_ctrl with SCAN_DIV=4, DEBOUNCE=8:
// press latency 11 clks, release latency 10 clks after the kpr change.
module tb_keypad_scan_ctrl;
  logic clk = 1'b0;
  logic reset_n;
  int   total = 0;
  int   bad   = 0;

  keypad_scan_if kp ();

  keypad_scan_ctrl #(.SCAN_DIV(4), .DEBOUNCE(8)) dut (
    .clk     (clk),
    .reset_n (reset_n),
    .kp      (kp)
  );

  always #5 clk = ~clk;

  initial begin
    #200000;
    $display("FAIL watchdog: sim time limit reached");
    $fatal(1, "watchdog");
  end

  task automatic tick(input int n);
    repeat (n) begin
      @(posedge clk);
      #1;
    end
  endtask

  // Returns one step after the edge on which kpc freshly switched to target.
  task automatic wait_col(input logic [3:0] target, input string tag);
    int n = 0;
    while (kp.kpc === target && n < 40) begin tick(1); n++; end
    while (kp.kpc !== target && n < 80) begin tick(1); n++; end
    total++;
    if (kp.kpc !== target) begin
      bad++;
      $display("FAIL %s: kpc=%b want %b (timeout)", tag, kp.kpc, target);
    end
  endtask

  task automatic release_key(input string tag);
    int n = 0;
    kp.kpr = 4'hF;
    while (kp.key_held !== 1'b0 && n < 30) begin tick(1); n++; end
    total++;
    if (kp.key_held !== 1'b0) begin
      bad++;
      $display("FAIL %s: key_held=%b want 0 (timeout)", tag, kp.key_held);
    end
  endtask

  task automatic pulse_ready();
    kp.key_ready = 1'b1;
    tick(1);
    kp.key_ready = 1'b0;
  endtask

  task automatic test_reset();
    logic [3:0] exp_col [5];
    int         gap     [5];
    exp_col = '{4'b0111, 4'b1011, 4'b1101, 4'b1110, 4'b0111};
    gap     = '{3, 1, 4, 4, 4};
    reset_n = 1'b0;
    kp.kpr = 4'hF; kp.key_ready = 1'b0; kp.clr_overrun = 1'b0;
    #12;
    total += 5;
    if (kp.kpc !== 4'b0111) begin bad++; $display("FAIL rst_kpc: got %b want 0111", kp.kpc); end
    if (kp.key_code !== 4'd0) begin bad++; $display("FAIL rst_code: got %0d want 0", kp.key_code); end
    if (kp.key_valid !== 1'b0) begin bad++; $display("FAIL rst_valid: got %b want 0", kp.key_valid); end
    if (kp.key_held !== 1'b0) begin bad++; $display("FAIL rst_held: got %b want 0", kp.key_held); end
    if (kp.overrun !== 1'b0) begin bad++; $display("FAIL rst_ovr: got %b want 0", kp.overrun); end
    @(negedge clk) reset_n = 1'b1;
    for (int i = 0; i < 5; i++) begin
      tick(gap[i]);
      total++;
      if (kp.kpc !== exp_col[i] || kp.key_valid !== 1'b0) begin
        bad++;
        $display("FAIL scan_step%0d: kpc=%b valid=%b want %b/0", i, kp.kpc, kp.key_valid, exp_col[i]);
      end
    end
  endtask

  task automatic test_press();
    wait_col(4'b1101, "press_col2");
    kp.kpr = 4'b1011;
    tick(10);
    total++;
    if (kp.key_valid !== 1'b0 || kp.kpc !== 4'b1101) begin
      bad++; $display("FAIL press_early: valid=%b kpc=%b want 0/1101", kp.key_valid, kp.kpc);
    end
    tick(1);
    total++;
    if (kp.key_valid !== 1'b1 || kp.key_code !== 4'd6 || kp.key_held !== 1'b1) begin
      bad++;
      $display("FAIL press_report: valid=%b code=%0d held=%b want 1/6/1", kp.key_valid, kp.key_code, kp.key_held);
    end
    pulse_ready();
    total++;
    if (kp.key_valid !== 1'b0) begin bad++; $display("FAIL press_consume: valid=%b want 0", kp.key_valid); end
    tick(5);
    kp.kpr = 4'hF;
    tick(9);
    total++;
    if (kp.key_held !== 1'b1) begin bad++; $display("FAIL release_early: held=%b want 1", kp.key_held); end
    tick(1);
    total++;
    if (kp.key_held !== 1'b0 || kp.kpc !== 4'b1110 || kp.key_valid !== 1'b0) begin
      bad++;
      $display("FAIL release_done: held=%b kpc=%b valid=%b want 0/1110/0", kp.key_held, kp.kpc, kp.key_valid);
    end
  endtask

  task automatic test_bounce();
    bit seen = 1'b0;
    for (int i = 0; i < 40; i++) begin
      kp.kpr = (((i / 3) % 2) == 0) ? 4'b1011 : 4'hF;
      tick(1);
      if (kp.key_valid !== 1'b0) seen = 1'b1;
    end
    kp.kpr = 4'hF;
    tick(4);
    if (kp.key_valid !== 1'b0) seen = 1'b1;
    total++;
    if (seen) begin bad++; $display("FAIL bounce_no_key: key_valid rose, want never"); end
    wait_col(4'b0111, "bounce_col0");
    kp.kpr = 4'b1011;
    tick(11);
    total++;
    if (kp.key_valid !== 1'b1 || kp.key_code !== 4'd4) begin
      bad++; $display("FAIL bounce_stable: valid=%b code=%0d want 1/4", kp.key_valid, kp.key_code);
    end
    pulse_ready();
    seen = 1'b0;
    for (int i = 0; i < 30; i++) begin
      tick(1);
      if (kp.key_valid !== 1'b0) seen = 1'b1;
    end
    total++;
    if (seen) begin bad++; $display("FAIL single_report: key_valid rose again while held"); end
    release_key("bounce_release");
  endtask

  task automatic test_chord();
    bit seen = 1'b0;
    wait_col(4'b0111, "chord_col0");
    kp.kpr = 4'b1001;
    for (int i = 0; i < 20; i++) begin
      tick(1);
      if (kp.key_valid !== 1'b0 || kp.key_held !== 1'b0) seen = 1'b1;
    end
    total++;
    if (seen) begin bad++; $display("FAIL chord_rejected: a key was reported, want none"); end
    kp.kpr = 4'hF;
    wait_col(4'b1011, "chord_scan_resumes");
    wait_col(4'b0111, "chord_back_col0");
    kp.kpr = 4'b0111;
    tick(11);
    total++;
    if (kp.key_valid !== 1'b1 || kp.key_code !== 4'd0) begin
      bad++; $display("FAIL key0: valid=%b code=%0d want 1/0", kp.key_valid, kp.key_code);
    end
    pulse_ready();
    release_key("key0_release");
  endtask

  task automatic test_overrun();
    kp.key_ready = 1'b0;
    wait_col(4'b1011, "ovr_col1");
    kp.kpr = 4'b1011;
    tick(11);
    total++;
    if (kp.key_valid !== 1'b1 || kp.key_code !== 4'd5) begin
      bad++; $display("FAIL key5: valid=%b code=%0d want 1/5", kp.key_valid, kp.key_code);
    end
    release_key("key5_release");
    wait_col(4'b1101, "ovr_col2");
    kp.kpr = 4'b1101;
    kp.clr_overrun = 1'b1;
    tick(10);
    total++;
    if (kp.overrun !== 1'b0) begin bad++; $display("FAIL ovr_early: overrun=%b want 0", kp.overrun); end
    tick(1);
    total++;
    if (kp.overrun !== 1'b1 || kp.key_code !== 4'd5 || kp.key_valid !== 1'b1) begin
      bad++;
      $display("FAIL ovr_set_wins: overrun=%b code=%0d valid=%b want 1/5/1", kp.overrun, kp.key_code, kp.key_valid);
    end
    kp.clr_overrun = 1'b0;
    tick(1);
    total++;
    if (kp.overrun !== 1'b1) begin bad++; $display("FAIL ovr_sticky: overrun=%b want 1", kp.overrun); end
    kp.clr_overrun = 1'b1;
    tick(1);
    kp.clr_overrun = 1'b0;
    total++;
    if (kp.overrun !== 1'b0) begin bad++; $display("FAIL ovr_clear: overrun=%b want 0", kp.overrun); end
    pulse_ready();
    total++;
    if (kp.key_valid !== 1'b0) begin bad++; $display("FAIL ovr_consume: valid=%b want 0", kp.key_valid); end
    release_key("key10_release");
  endtask

  task automatic test_back_to_back();
    wait_col(4'b1110, "b2b_col3");
    kp.kpr = 4'b0111;
    tick(11);
    total++;
    if (kp.key_valid !== 1'b1 || kp.key_code !== 4'd3) begin
      bad++; $display("FAIL key3: valid=%b code=%0d want 1/3", kp.key_valid, kp.key_code);
    end
    release_key("key3_release");
    wait_col(4'b0111, "b2b_col0");
    kp.kpr = 4'b1110;
    tick(10);
    kp.key_ready = 1'b1;
    tick(1);
    kp.key_ready = 1'b0;
    total++;
    if (kp.key_valid !== 1'b1 || kp.key_code !== 4'd12 || kp.overrun !== 1'b0) begin
      bad++;
      $display("FAIL b2b_swap: valid=%b code=%0d ovr=%b want 1/12/0", kp.key_valid, kp.key_code, kp.overrun);
    end
    tick(1);
    total++;
    if (kp.key_valid !== 1'b1 || kp.key_code !== 4'd12) begin
      bad++; $display("FAIL b2b_hold: valid=%b code=%0d want 1/12", kp.key_valid, kp.key_code);
    end
    pulse_ready();
    release_key("key12_release");
  endtask

  task automatic test_reset_mid();
    wait_col(4'b1110, "rst_col3");
    kp.kpr = 4'b1110;
    tick(11);
    total++;
    if (kp.key_valid !== 1'b1 || kp.key_code !== 4'd15 || kp.key_held !== 1'b1) begin
      bad++;
      $display("FAIL key15: valid=%b code=%0d held=%b want 1/15/1", kp.key_valid, kp.key_code, kp.key_held);
    end
    #3 reset_n = 1'b0;
    #1;
    total++;
    if (kp.kpc !== 4'b0111 || kp.key_code !== 4'd0 || kp.key_valid !== 1'b0 ||
        kp.key_held !== 1'b0 || kp.overrun !== 1'b0) begin
      bad++;
      $display("FAIL async_reset: kpc=%b code=%0d valid=%b held=%b ovr=%b want 0111/0/0/0/0",
               kp.kpc, kp.key_code, kp.key_valid, kp.key_held, kp.overrun);
    end
    kp.kpr = 4'hF;
    @(negedge clk) reset_n = 1'b1;
    tick(3);
    total++;
    if (kp.kpc !== 4'b0111) begin bad++; $display("FAIL post_rst_col0: kpc=%b want 0111", kp.kpc); end
    tick(1);
    total++;
    if (kp.kpc !== 4'b1011 || kp.key_valid !== 1'b0) begin
      bad++; $display("FAIL post_rst_scan: kpc=%b valid=%b want 1011/0", kp.kpc, kp.key_valid);
    end
  endtask

  initial begin
    test_reset();
    test_press();
    test_bounce();
    test_chord();
    test_overrun();
    test_back_to_back();
    test_reset_mid();
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
